// File: rtl/tv80_dma_arb_pkg.sv
// Shared types and constants for the TV80 DMA bus arbiter.
// Holds the FSM state encoding, the master-index type (wide enough for
// up to 8 masters) and the idle value of the muxed control bus.
package tv80_dma_arb_pkg;

  // Index width covers NREQ <= 8.
  localparam int IDX_W = 3;

  // ctl_n bit order is {mreq_n, iorq_n, rd_n, wr_n}; all high = no cycle.
  localparam logic [3:0] CTL_IDLE = 4'b1111;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BUSREQ  = 3'd1,
    ST_OWNED   = 3'd2,
    ST_HANDOFF = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/tv80_dma_arb_if.sv
// Bus bundle between the DMA masters, the TV80 bus handshake and the
// system-bus decode. master = arbiter side, slave = masters/CPU side.
// Ports: req/gnt/preempt, busrq_n/busak_n, bus_oe, m_A/m_dout/m_ctl_n in, A/dout/ctl_n out.
interface tv80_dma_arb_if #(parameter int NREQ = 2);

  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      gnt;
  logic                 preempt;
  logic                 busrq_n;
  logic                 busak_n;
  logic                 bus_oe;
  logic [16*NREQ-1:0]   m_A;
  logic [8*NREQ-1:0]    m_dout;
  logic [4*NREQ-1:0]    m_ctl_n;
  logic [15:0]          A;
  logic [7:0]           dout;
  logic [3:0]           ctl_n;

  modport master (
    input  req, busak_n, m_A, m_dout, m_ctl_n,
    output gnt, preempt, busrq_n, bus_oe, A, dout, ctl_n
  );

  modport slave (
    output req, busak_n, m_A, m_dout, m_ctl_n,
    input  gnt, preempt, busrq_n, bus_oe, A, dout, ctl_n
  );

endinterface

// File: rtl/tv80_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping.
// Ports: req (NREQ) and last (index) in; winner (index) and valid out.
// The most recently served master therefore has lowest priority.
module tv80_rr_pick
  import tv80_dma_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  idx_t            last,
  output idx_t            winner,
  output logic            valid
);

  // Walk from farthest to nearest so the nearest candidate is written last.
  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if ((req & (NREQ'(1) << idx)) != '0) begin
        winner = idx_t'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tv80_dma_arb.sv
// Shares the TV80 external bus between the CPU and NREQ DMA masters via busrq_n/busak_n,
// round-robin grant, and a mux of the owner's A/dout/ctl_n onto the system bus.
// Ports: clk, reset (sync, active high), bus (tv80_dma_arb_if.master).
module tv80_dma_arb
  import tv80_dma_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MAX_HOLD  = 64,
  parameter int BACK2BACK = 0
) (
  input  logic           clk,
  input  logic           reset,
  tv80_dma_arb_if.master bus
);

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t          state, state_nxt;
  idx_t            sel, sel_nxt, last, last_nxt;
  logic [NREQ-1:0] gnt, gnt_nxt;
  logic            bus_oe, oe_nxt;
  logic            preempt, pre_nxt;
  logic            busrq_n, brq_nxt;
  logic [7:0]      hold_cnt, hold_nxt, hold_inc;

  idx_t            pick_idx;
  logic            pick_vld;
  logic [NREQ-1:0] sel_oh, pick_oh;
  logic            req_sel, others;

  tv80_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req),
    .last   (last),
    .winner (pick_idx),
    .valid  (pick_vld)
  );

  assign sel_oh   = NREQ'(1) << sel;
  assign pick_oh  = NREQ'(1) << pick_idx;
  assign req_sel  = (bus.req & sel_oh) != '0;
  assign others   = (bus.req & ~sel_oh) != '0;
  assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      sel      <= '0;
      last     <= idx_t'(NREQ - 1);
      gnt      <= '0;
      bus_oe   <= 1'b0;
      preempt  <= 1'b0;
      busrq_n  <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      last     <= last_nxt;
      gnt      <= gnt_nxt;
      bus_oe   <= oe_nxt;
      preempt  <= pre_nxt;
      busrq_n  <= brq_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    last_nxt  = last;
    gnt_nxt   = gnt;
    oe_nxt    = bus_oe;
    pre_nxt   = preempt;
    brq_nxt   = busrq_n;
    hold_nxt  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          sel_nxt   = pick_idx;
          brq_nxt   = 1'b0;
          state_nxt = ST_BUSREQ;
        end
      end
      ST_BUSREQ: begin
        brq_nxt = 1'b0;
        if (!bus.busak_n) begin
          if (req_sel) begin
            gnt_nxt   = sel_oh;
            oe_nxt    = 1'b1;
            hold_nxt  = '0;
            last_nxt  = sel;
            state_nxt = ST_OWNED;
          end else begin
            // Requester withdrew before the CPU let go: hand the bus straight back.
            brq_nxt   = 1'b1;
            state_nxt = ST_RELEASE;
          end
        end
      end
      ST_OWNED: begin
        // Release (req drop or CPU reclaiming the bus) takes priority over preempt.
        if (bus.busak_n || !req_sel) begin
          gnt_nxt = '0;
          oe_nxt  = 1'b0;
          pre_nxt = 1'b0;
          if (!bus.busak_n && (BACK2BACK != 0) && others) begin
            state_nxt = ST_HANDOFF;
          end else begin
            brq_nxt   = 1'b1;
            state_nxt = ST_RELEASE;
          end
        end else begin
          hold_nxt = hold_inc;
          // Registered, so it is visible in the cycle where hold_cnt reaches the limit.
          pre_nxt  = (hold_inc == HOLD_MAX) && others;
        end
      end
      ST_HANDOFF: begin
        // Dead cycle with bus_oe low; pick the next owner from live requests.
        if (!bus.busak_n && pick_vld) begin
          sel_nxt   = pick_idx;
          gnt_nxt   = pick_oh;
          oe_nxt    = 1'b1;
          hold_nxt  = '0;
          last_nxt  = pick_idx;
          state_nxt = ST_OWNED;
        end else begin
          brq_nxt   = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        brq_nxt = 1'b1;
        if (bus.busak_n) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
        oe_nxt    = 1'b0;
        pre_nxt   = 1'b0;
        brq_nxt   = 1'b1;
      end
    endcase
  end

  // System-bus mux, driven from registered sel/bus_oe only.
  always_comb begin
    bus.A     = '0;
    bus.dout  = '0;
    bus.ctl_n = CTL_IDLE;
    if (bus_oe) begin
      for (int i = 0; i < NREQ; i++) begin
        if (sel == idx_t'(i)) begin
          bus.A     = bus.m_A[16*i +: 16];
          bus.dout  = bus.m_dout[8*i +: 8];
          bus.ctl_n = bus.m_ctl_n[4*i +: 4];
        end
      end
    end
  end

  assign bus.gnt     = gnt;
  assign bus.bus_oe  = bus_oe;
  assign bus.preempt = preempt;
  assign bus.busrq_n = busrq_n;

endmodule

// File: tb/tb_tv80_dma_arb.sv
// Bench for tv80_dma_arb: dut_a (BACK2BACK=0) and dut_b (BACK2BACK=1), both MAX_HOLD=8.
// A CPU model answers busrq_n after LAT cycles; a round-robin reference model
// predicts every grant and the preempt flag from observed requests.
`timescale 1ns/1ps
module tb_tv80_dma_arb;

  localparam int N   = 2;
  localparam int MH  = 8;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tv80_dma_arb_if #(.NREQ(N)) ifa ();
  tv80_dma_arb_if #(.NREQ(N)) ifb ();

  tv80_dma_arb #(.NREQ(N), .MAX_HOLD(MH), .BACK2BACK(0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  tv80_dma_arb #(.NREQ(N), .MAX_HOLD(MH), .BACK2BACK(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_a    = 0;
  int cnt_b    = 0;
  int last_m   = N - 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round robin from the rule: first requester at last+1, last+2, ... mod N.
  function automatic int rr(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [31:0] mux_exp(input logic [N-1:0] g, input logic [16*N-1:0] ma,
                                          input logic [8*N-1:0] md, input logic [4*N-1:0] mc);
    mux_exp = {4'h0, 4'hF, 8'h00, 16'h0000};
    for (int i = 0; i < N; i++)
      if (g[i]) mux_exp = {4'h0, mc[4*i +: 4], md[8*i +: 8], ma[16*i +: 16]};
  endfunction

  task automatic inv(input string tag, input logic [N-1:0] g, input logic oe, input logic ak,
                     input logic [31:0] muxed, input logic [31:0] expected);
    chk({tag, "_onehot0"}, 32'($onehot0(g)), 1);
    chk({tag, "_gnt_oe"}, 32'(g != '0), 32'(oe));
    if (g != '0) chk({tag, "_gnt_busak"}, 32'(ak), 0);
    chk({tag, "_mux"}, muxed, expected);
  endtask

  // Sample away from the active edge, then step the CPU models.
  task automatic tick();
    @(negedge clk);
    inv("a", ifa.gnt, ifa.bus_oe, ifa.busak_n, {4'h0, ifa.ctl_n, ifa.dout, ifa.A},
        mux_exp(ifa.gnt, ifa.m_A, ifa.m_dout, ifa.m_ctl_n));
    inv("b", ifb.gnt, ifb.bus_oe, ifb.busak_n, {4'h0, ifb.ctl_n, ifb.dout, ifb.A},
        mux_exp(ifb.gnt, ifb.m_A, ifb.m_dout, ifb.m_ctl_n));
    if (ifa.busrq_n) begin cnt_a = 0; ifa.busak_n = 1'b1; end
    else begin if (cnt_a < LAT) cnt_a++; if (cnt_a >= LAT) ifa.busak_n = 1'b0; end
    if (ifb.busrq_n) begin cnt_b = 0; ifb.busak_n = 1'b1; end
    else begin if (cnt_b < LAT) cnt_b++; if (cnt_b >= LAT) ifb.busak_n = 1'b0; end
  endtask

  // Masters on dut_a; every grant and preempt checked against the model.
  task automatic run_a(input int cycles, input bit rnd, input int min_grants);
    logic [N-1:0] g, prev_g;
    int held[N], hold_len[N];
    int exp_next, own_k, grants;
    bit prev_brq, saw_rel;
    prev_g = ifa.gnt; prev_brq = ifa.busrq_n; saw_rel = 1'b1;
    exp_next = -1; own_k = 0; grants = 0;
    for (int i = 0; i < N; i++) begin held[i] = 0; hold_len[i] = 3; end
    for (int c = 0; c < cycles; c++) begin
      tick();
      g = ifa.gnt;
      if (prev_brq && !ifa.busrq_n) exp_next = rr(ifa.req, last_m);
      if (g != '0 && prev_g == '0) begin
        chk("grant_order", 32'(g), (exp_next < 0) ? 32'd0 : (32'd1 << exp_next));
        chk("busrq_between", 32'(saw_rel), 1);
        last_m = exp_next; own_k = 0; saw_rel = 1'b0; grants++;
      end
      if (g != '0) begin
        own_k++;
        chk("preempt", 32'(ifa.preempt), 32'((own_k - 1 >= MH) && ((ifa.req & ~g) != '0)));
      end else begin
        chk("preempt_idle", 32'(ifa.preempt), 0);
      end
      if (ifa.busrq_n) saw_rel = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          held[i]++;
          if (held[i] >= hold_len[i]) begin ifa.req[i] = 1'b0; held[i] = 0; end
        end else if (!ifa.req[i]) begin
          if (!rnd || $urandom_range(0, 3) == 0) begin
            ifa.req[i] = 1'b1;
            hold_len[i] = rnd ? int'($urandom_range(1, 14)) : 3;
          end
        end
      end
      if (rnd) begin
        ifa.m_A = 32'($urandom); ifa.m_dout = 16'($urandom); ifa.m_ctl_n = 8'($urandom);
      end
      prev_g = g; prev_brq = ifa.busrq_n;
    end
    chk("grant_count_ok", 32'(grants >= min_grants), 1);
    ifa.req = '0;
    repeat (12) tick();
  endtask

  initial begin
    reset = 1'b1;
    ifa.req = '0; ifb.req = '0; ifa.busak_n = 1'b1; ifb.busak_n = 1'b1;
    ifa.m_A = {16'hBEEF, 16'h1234}; ifa.m_dout = {8'h3C, 8'hA5}; ifa.m_ctl_n = {4'b0110, 4'b0101};
    ifb.m_A = {16'hCAFE, 16'h5678}; ifb.m_dout = {8'h77, 8'h11}; ifb.m_ctl_n = {4'b1010, 4'b0111};

    // 1: reset state, held 10 cycles after release
    repeat (3) tick();
    chk("rst_busrq", 32'(ifa.busrq_n), 1);
    chk("rst_gnt", 32'(ifa.gnt), 0);
    chk("rst_preempt", 32'(ifa.preempt), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busrq", 32'(ifa.busrq_n), 1);
      chk("idle_gnt", 32'(ifa.gnt), 0);
      chk("idle_oe", 32'(ifa.bus_oe), 0);
      chk("idle_ctl", 32'(ifa.ctl_n), 32'hF);
      chk("idle_busrq_b", 32'(ifb.busrq_n), 1);
    end

    // 2: single master
    ifa.req = 2'b01;
    tick();
    chk("t2_busrq_low", 32'(ifa.busrq_n), 0);
    chk("t2_no_gnt", 32'(ifa.gnt), 0);
    for (int i = 0; i < 20 && ifa.busak_n !== 1'b0; i++) tick();
    chk("t2_busak", 32'(ifa.busak_n), 0);
    chk("t2_gnt_before_edge", 32'(ifa.gnt), 0);
    tick();
    chk("t2_gnt", 32'(ifa.gnt), 32'h1);
    chk("t2_oe", 32'(ifa.bus_oe), 1);
    chk("t2_A", 32'(ifa.A), 32'h1234);
    chk("t2_ctl", 32'(ifa.ctl_n), 32'h5);
    repeat (3) tick();
    chk("t2_gnt_held", 32'(ifa.gnt), 32'h1);
    ifa.req = 2'b00;
    tick();
    chk("t2_rel_busrq", 32'(ifa.busrq_n), 1);
    chk("t2_rel_gnt", 32'(ifa.gnt), 0);
    chk("t2_rel_ctl", 32'(ifa.ctl_n), 32'hF);
    repeat (4) tick();
    last_m = 0;

    // 3: both masters keep re-requesting, grants must alternate
    run_a(150, 1'b0, 4);

    // 4: preempt timing, and release beating preempt
    ifa.req = 2'b01;
    for (int i = 0; i < 30 && ifa.gnt == '0; i++) tick();
    chk("t4_gnt0", 32'(ifa.gnt), 32'h1);
    for (int k = 1; k <= 20; k++) begin
      if (k == 8) chk("t4_pre_k8", 32'(ifa.preempt), 0);
      if (k == 9) chk("t4_pre_k9", 32'(ifa.preempt), 1);
      if (k == 2) ifa.req[1] = 1'b1;
      if (k < 20) tick();
    end
    chk("t4_gnt_kept", 32'(ifa.gnt), 32'h1);
    ifa.req[0] = 1'b0;
    tick();
    chk("t4_rel_gnt", 32'(ifa.gnt), 0);
    chk("t4_rel_pre", 32'(ifa.preempt), 0);
    for (int i = 0; i < 30 && ifa.gnt == '0; i++) tick();
    chk("t4_gnt1", 32'(ifa.gnt), 32'h2);
    ifa.req[0] = 1'b1;
    repeat (7) tick();
    ifa.req[1] = 1'b0;
    tick();
    chk("t4_sim_gnt", 32'(ifa.gnt), 0);
    chk("t4_sim_pre", 32'(ifa.preempt), 0);
    for (int i = 0; i < 30 && ifa.gnt == '0; i++) tick();
    chk("t4_gnt0_again", 32'(ifa.gnt), 32'h1);
    ifa.req = '0;
    repeat (8) tick();
    last_m = 0;

    // Randomized traffic against the model
    run_a(1500, 1'b1, 20);

    // 5: back-to-back handoff on dut_b
    ifb.req = 2'b11;
    for (int i = 0; i < 30 && ifb.gnt == '0; i++) tick();
    chk("t5_first", 32'(ifb.gnt), 32'h1);
    repeat (3) tick();
    ifb.req = 2'b10;
    tick();
    chk("t5_dead_gnt", 32'(ifb.gnt), 0);
    chk("t5_dead_oe", 32'(ifb.bus_oe), 0);
    chk("t5_dead_busrq", 32'(ifb.busrq_n), 0);
    tick();
    chk("t5_handoff", 32'(ifb.gnt), 32'h2);
    chk("t5_A", 32'(ifb.A), 32'hCAFE);
    ifb.req = '0;
    tick();
    chk("t5_end_busrq", 32'(ifb.busrq_n), 1);

    // 6: reset while master 0 owns the bus
    ifa.m_A = {16'hBEEF, 16'h1234}; ifa.m_dout = {8'h3C, 8'hA5}; ifa.m_ctl_n = {4'b0110, 4'b0101};
    ifa.req = 2'b01;
    for (int i = 0; i < 30 && ifa.gnt == '0; i++) tick();
    chk("t6_owned", 32'(ifa.gnt), 32'h1);
    tick();
    reset = 1'b1; ifa.req = 2'b11;
    tick();
    chk("t6_gnt", 32'(ifa.gnt), 0);
    chk("t6_oe", 32'(ifa.bus_oe), 0);
    chk("t6_busrq", 32'(ifa.busrq_n), 1);
    chk("t6_ctl", 32'(ifa.ctl_n), 32'hF);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 30 && ifa.gnt == '0; i++) tick();
    chk("t6_first_after_rst", 32'(ifa.gnt), 32'h1);
    ifa.req = '0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
